// File: rtl/rc5_decryptor_if.sv
// ============================================================================
// Module   : rc5_decryptor_if
// Brief    : Start/operand/result handshake and S-RAM read port of the RC5
//            block decryptor.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rc5_decryptor_if #(
    parameter int W = 32,
    parameter int R = 12
);
    localparam int T_LENGTH = $clog2(2 * R + 2);

    logic                iKeyReady;
    logic                iStart;
    logic [W-1:0]        iA;
    logic [W-1:0]        iB;
    logic [T_LENGTH-1:0] oS_address;
    logic [W-1:0]        iS_data;
    logic [W-1:0]        oA;
    logic [W-1:0]        oB;
    logic                oBusy;
    logic                oDone;

    // Decryptor side.
    modport slave (
        input  iKeyReady, iStart, iA, iB, iS_data,
        output oS_address, oA, oB, oBusy, oDone
    );

    // Controller / key-RAM side.
    modport master (
        output iKeyReady, iStart, iA, iB, iS_data,
        input  oS_address, oA, oB, oBusy, oDone
    );
endinterface

`default_nettype wire

// File: rtl/rc5_decryptor.sv
// ============================================================================
// Module   : rc5_decryptor
// Brief    : Iterative RC5-W/R/b block decryptor reading the expanded key
//            table S through one synchronous-read port, 4R+6 cycles/block.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rc5_decryptor #(
    parameter int W = 32,
    parameter int R = 12
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rc5_decryptor_if.slave    bus
);
    localparam int LG       = $clog2(W);
    localparam int T        = 2 * R + 2;
    localparam int T_LENGTH = $clog2(T);
    localparam int RW       = $clog2(R + 1);

    localparam logic [T_LENGTH-1:0] c_ADDR_TOP = T_LENGTH'(T - 1);
    localparam logic [T_LENGTH-1:0] c_ADDR_ONE = T_LENGTH'(1);
    localparam logic [RW-1:0]       c_ROUNDS   = RW'(R);
    localparam logic [RW-1:0]       c_RND_ONE  = RW'(1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WAIT_B  = 4'd1;
    localparam logic [3:0] S_DEC_B   = 4'd2;
    localparam logic [3:0] S_WAIT_A  = 4'd3;
    localparam logic [3:0] S_DEC_A   = 4'd4;
    localparam logic [3:0] S_WAIT_FB = 4'd5;
    localparam logic [3:0] S_FIN_B   = 4'd6;
    localparam logic [3:0] S_WAIT_FA = 4'd7;
    localparam logic [3:0] S_FIN_A   = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;

    logic [3:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [RW-1:0] r_round;

    logic [W-1:0]  w_aMinusS;
    logic [W-1:0]  w_bMinusS;

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LG-1:0] s);
        logic [2*W-1:0] t;
        t = {x, x} >> s;
        return t[W-1:0];
    endfunction

    assign w_aMinusS = r_a - bus.iS_data;
    assign w_bMinusS = r_b - bus.iS_data;

    // WAIT states cover the one-cycle RAM read latency; DEC/FIN states consume iS_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_a            <= '0;
            r_b            <= '0;
            r_round        <= c_ROUNDS;
            bus.oS_address <= '0;
            bus.oA         <= '0;
            bus.oB         <= '0;
            bus.oBusy      <= 1'b0;
            bus.oDone      <= 1'b0;
        end else begin
            bus.oDone <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.iStart && bus.iKeyReady) begin
                        r_a            <= bus.iA;
                        r_b            <= bus.iB;
                        r_round        <= c_ROUNDS;
                        bus.oS_address <= c_ADDR_TOP;
                        bus.oBusy      <= 1'b1;
                        r_state        <= S_WAIT_B;
                    end
                end
                S_WAIT_B: r_state <= S_DEC_B;
                S_DEC_B: begin
                    r_b            <= rotr(w_bMinusS, r_a[LG-1:0]) ^ r_a;
                    bus.oS_address <= bus.oS_address - c_ADDR_ONE;
                    r_state        <= S_WAIT_A;
                end
                S_WAIT_A: r_state <= S_DEC_A;
                S_DEC_A: begin
                    r_a <= rotr(w_aMinusS, r_b[LG-1:0]) ^ r_b;
                    if (r_round > c_RND_ONE) begin
                        r_round        <= r_round - c_RND_ONE;
                        bus.oS_address <= bus.oS_address - c_ADDR_ONE;
                        r_state        <= S_WAIT_B;
                    end else begin
                        bus.oS_address <= c_ADDR_ONE;
                        r_state        <= S_WAIT_FB;
                    end
                end
                S_WAIT_FB: r_state <= S_FIN_B;
                S_FIN_B: begin
                    r_b            <= w_bMinusS;
                    bus.oS_address <= '0;
                    r_state        <= S_WAIT_FA;
                end
                S_WAIT_FA: r_state <= S_FIN_A;
                S_FIN_A: begin
                    r_a       <= w_aMinusS;
                    bus.oA    <= w_aMinusS;
                    bus.oB    <= r_b;
                    bus.oDone <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    bus.oBusy <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    bus.oBusy <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire
